// File: rtl/rv_decode_stage_pkg.sv
// Shared constants, immediate kinds and the decoded-bundle layout for the RV32I decode stage.
package rv_decode_stage_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned REG_AW  = 5;

  // Major opcodes understood by the stage
  localparam logic [6:0] OPCODE_OP    = 7'b0110011;
  localparam logic [6:0] OPCODE_OPIMM = 7'b0010011;
  localparam logic [6:0] OPCODE_LUI   = 7'b0110111;

  // funct3/funct7 encodings, named as the ALU names them
  localparam logic [2:0] ADDFUNCT3  = 3'b000;
  localparam logic [2:0] SLLFUNCT3  = 3'b001;
  localparam logic [2:0] SRLFUNCT3  = 3'b101;
  localparam logic [6:0] BASEFUNCT7 = 7'b0000000;
  localparam logic [6:0] SUBFUNCT7  = 7'b0100000;
  localparam logic [6:0] SRAFUNCT7  = 7'b0100000;

  // Where op2 comes from; also tells the refresh logic which operands track registers
  typedef enum logic [1:0] {
    IMM_NONE  = 2'd0,
    IMM_I     = 2'd1,
    IMM_SHAMT = 2'd2,
    IMM_U     = 2'd3
  } imm_kind_e;

  // Decoded bundle held in the output pipeline register
  typedef struct packed {
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic [4:0]       rd;
    logic [XLEN-1:0]  op1;
    logic [XLEN-1:0]  op2;
    logic             illegal;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    imm_kind_e        imm_kind;
  } decoded_t;

  // Sign-extend a 12-bit I-type immediate to the datapath width
  function automatic logic [XLEN-1:0] sext12(input logic [11:0] imm);
    return {{(XLEN-12){imm[11]}}, imm};
  endfunction

endpackage

// File: rtl/rv_decode_stage_regfile.sv
// Integer register file: one write port, two combinational read ports with write bypass, x0 reads zero.
module rv_regfile #(
  parameter int unsigned NREGS = 32,
  parameter int unsigned WIDTH = 32,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr1,
  input  logic [AW-1:0]    raddr2,
  output logic [WIDTH-1:0] rdata1,
  output logic [WIDTH-1:0] rdata2
);

  logic [WIDTH-1:0] regs [NREGS];

  // Storage; writes to x0 are discarded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  // Read port 1 with same-cycle write bypass
  always_comb begin
    rdata1 = '0;
    if (raddr1 != '0) begin
      rdata1 = (we && (waddr == raddr1)) ? wdata : regs[raddr1];
    end
  end

  // Read port 2 with same-cycle write bypass
  always_comb begin
    rdata2 = '0;
    if (raddr2 != '0) begin
      rdata2 = (we && (waddr == raddr2)) ? wdata : regs[raddr2];
    end
  end

endmodule

// File: rtl/rv_decode_stage.sv
// RV32I decode stage: reads operands, decodes OP/OPIMM/LUI and holds one bundle toward execute.
module rv_decode_stage
  import rv_decode_stage_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic               flush,
  input  logic               wb_en,
  input  logic [REG_AW-1:0]  wb_rd,
  input  logic [WIDTH-1:0]   wb_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_op1,
  output logic [WIDTH-1:0]   out_op2,
  output logic [6:0]         out_opcode,
  output logic [2:0]         out_funct3,
  output logic [6:0]         out_funct7,
  output logic [4:0]         out_rd,
  output logic               out_illegal
);

  logic [6:0]        f_opcode;
  logic [2:0]        f_funct3;
  logic [6:0]        f_funct7;
  logic [4:0]        f_rs1;
  logic [4:0]        f_rs2;
  logic [4:0]        f_rd;
  logic [WIDTH-1:0]  rf_rs1;
  logic [WIDTH-1:0]  rf_rs2;
  decoded_t          dec;
  decoded_t          held_q;
  decoded_t          held_nxt;
  logic              out_valid_q;

  assign f_opcode = in_instr[6:0];
  assign f_rd     = in_instr[11:7];
  assign f_funct3 = in_instr[14:12];
  assign f_rs1    = in_instr[19:15];
  assign f_rs2    = in_instr[24:20];
  assign f_funct7 = in_instr[31:25];

  // The bundle slot is free when empty or draining this cycle
  assign in_ready = !out_valid_q || out_ready;

  rv_regfile #(
    .NREGS (NREGS),
    .WIDTH (WIDTH)
  ) u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (wb_en),
    .waddr  (wb_rd),
    .wdata  (wb_data),
    .raddr1 (f_rs1),
    .raddr2 (f_rs2),
    .rdata1 (rf_rs1),
    .rdata2 (rf_rs2)
  );

  // Decode the incoming word into an ALU bundle; unknown opcodes become an all-zero illegal bundle
  always_comb begin
    dec          = '0;
    dec.imm_kind = IMM_NONE;
    case (f_opcode)
      OPCODE_OP: begin
        dec.opcode  = OPCODE_OP;
        dec.funct3  = f_funct3;
        dec.funct7  = f_funct7;
        dec.rd      = f_rd;
        dec.rs1     = f_rs1;
        dec.rs2     = f_rs2;
        dec.op1     = XLEN'(rf_rs1);
        dec.op2     = XLEN'(rf_rs2);
        dec.illegal = !((f_funct7 == BASEFUNCT7) ||
                        ((f_funct7 == SUBFUNCT7) &&
                         ((f_funct3 == ADDFUNCT3) || (f_funct3 == SRLFUNCT3))));
      end
      OPCODE_OPIMM: begin
        dec.opcode   = OPCODE_OPIMM;
        dec.funct3   = f_funct3;
        dec.funct7   = BASEFUNCT7;
        dec.rd       = f_rd;
        dec.rs1      = f_rs1;
        dec.op1      = XLEN'(rf_rs1);
        dec.op2      = sext12(in_instr[31:20]);
        dec.imm_kind = IMM_I;
        if (f_funct3 == SLLFUNCT3) begin
          dec.funct7   = f_funct7;
          dec.op2      = XLEN'(f_rs2);
          dec.imm_kind = IMM_SHAMT;
          dec.illegal  = (f_funct7 != BASEFUNCT7);
        end else if (f_funct3 == SRLFUNCT3) begin
          dec.funct7   = f_funct7;
          dec.op2      = XLEN'(f_rs2);
          dec.imm_kind = IMM_SHAMT;
          dec.illegal  = !((f_funct7 == BASEFUNCT7) || (f_funct7 == SRAFUNCT7));
        end
      end
      OPCODE_LUI: begin
        // Executed as ADDI rd, x0, imm<<12 so the ALU needs no LUI path
        dec.opcode   = OPCODE_OPIMM;
        dec.funct3   = ADDFUNCT3;
        dec.funct7   = BASEFUNCT7;
        dec.rd       = f_rd;
        dec.op2      = XLEN'({in_instr[31:12], 12'b0});
        dec.imm_kind = IMM_U;
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
  end

  // Refresh register-sourced operands of a stalled bundle from writeback
  always_comb begin
    held_nxt = held_q;
    if (wb_en && (wb_rd != '0) && !held_q.illegal) begin
      if ((held_q.imm_kind != IMM_U) && (wb_rd == held_q.rs1)) begin
        held_nxt.op1 = XLEN'(wb_data);
      end
      if ((held_q.imm_kind == IMM_NONE) && (wb_rd == held_q.rs2)) begin
        held_nxt.op2 = XLEN'(wb_data);
      end
    end
  end

  // Output pipeline register; flush wins over a simultaneous accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      held_q      <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (in_ready) begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        held_q <= dec;
      end
    end else begin
      held_q <= held_nxt;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_op1     = WIDTH'(held_q.op1);
  assign out_op2     = WIDTH'(held_q.op2);
  assign out_opcode  = held_q.opcode;
  assign out_funct3  = held_q.funct3;
  assign out_funct7  = held_q.funct7;
  assign out_rd      = held_q.rd;
  assign out_illegal = held_q.illegal;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Scoreboard bench for rv_decode_stage: directed instructions, expected bundles queued at issue.
module tb_rv_decode_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        flush;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_op1;
  logic [31:0] out_op2;
  logic [6:0]  out_opcode;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic [4:0]  out_rd;
  logic        out_illegal;

  typedef struct {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        illegal;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_pop    = 0;

  rv_decode_stage #(.WIDTH(32), .NREGS(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .flush       (flush),
    .wb_en       (wb_en),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_op1     (out_op1),
    .out_op2     (out_op2),
    .out_opcode  (out_opcode),
    .out_funct3  (out_funct3),
    .out_funct7  (out_funct7),
    .out_rd      (out_rd),
    .out_illegal (out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
    end
  endtask

  task automatic expect_b(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                          input logic [4:0] rd, input logic [31:0] op1, input logic [31:0] op2,
                          input logic ill);
    exp_t x;
    x.opcode = opc; x.funct3 = f3; x.funct7 = f7; x.rd = rd;
    x.op1 = op1; x.op2 = op2; x.illegal = ill;
    q.push_back(x);
  endtask

  // Present one instruction and hold it until the stage takes it
  task automatic send(input logic [31:0] instr);
    in_valid = 1'b1;
    in_instr = instr;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    chk($sformatf("send_ready_%08h", instr), 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every transfer toward execute must match the oldest expected bundle
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_bundle", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        chk($sformatf("b%0d.opcode", n_pop),  32'(out_opcode),  32'(e.opcode));
        chk($sformatf("b%0d.funct3", n_pop),  32'(out_funct3),  32'(e.funct3));
        chk($sformatf("b%0d.funct7", n_pop),  32'(out_funct7),  32'(e.funct7));
        chk($sformatf("b%0d.rd", n_pop),      32'(out_rd),      32'(e.rd));
        chk($sformatf("b%0d.op1", n_pop),     out_op1,          e.op1);
        chk($sformatf("b%0d.op2", n_pop),     out_op2,          e.op2);
        chk($sformatf("b%0d.illegal", n_pop), 32'(out_illegal), 32'(e.illegal));
        n_pop++;
      end
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; flush = 1'b0;
    wb_en = 1'b0; wb_rd = '0; wb_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_op1", out_op1, 32'd0);
    chk("rst_op2", out_op2, 32'd0);
    chk("rst_opcode", 32'(out_opcode), 32'd0);
    chk("rst_illegal", 32'(out_illegal), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // ADDI x1,x0,5 then writeback x1=5, then ADD x2,x1,x1
    expect_b(7'h13, 3'd0, 7'h00, 5'd1, 32'd0, 32'd5, 1'b0);
    send(32'h00500093);
    wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'd5;
    @(posedge clk); #1;
    wb_en = 1'b0;
    expect_b(7'h33, 3'd0, 7'h00, 5'd2, 32'd5, 32'd5, 1'b0);
    send(32'h00108133);

    // SRAI x3,x1,4 legal, then same with funct7=0100001
    expect_b(7'h13, 3'd5, 7'h20, 5'd3, 32'd5, 32'd4, 1'b0);
    send(32'h4040D193);
    expect_b(7'h13, 3'd5, 7'h21, 5'd3, 32'd5, 32'd4, 1'b1);
    send(32'h4240D193);

    // LUI x5,0x12345 as OPIMM ADD
    expect_b(7'h13, 3'd0, 7'h00, 5'd5, 32'd0, 32'h12345000, 1'b0);
    send(32'h123452B7);

    // OP with SUB bit on funct3=001 is illegal; unsupported opcode zeroes the bundle
    expect_b(7'h33, 3'd1, 7'h20, 5'd4, 32'd5, 32'd0, 1'b1);
    send(32'h40209233);
    expect_b(7'h00, 3'd0, 7'h00, 5'd0, 32'd0, 32'd0, 1'b1);
    send(32'h0000006F);
    idle(3);

    // Backpressure with writeback refresh of the held ADDI x6,x1,1
    out_ready = 1'b0;
    expect_b(7'h13, 3'd0, 7'h00, 5'd6, 32'hDEAD, 32'd1, 1'b0);
    send(32'h00108313);
    wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'hDEAD;
    in_valid = 1'b1; in_instr = 32'h00108133;
    @(negedge clk);
    chk("bp_in_ready_c0", 32'(in_ready), 32'd0);
    chk("bp_valid_c0", 32'(out_valid), 32'd1);
    chk("bp_op1_before", out_op1, 32'd5);
    @(posedge clk); #1;
    wb_en = 1'b0;
    @(negedge clk);
    chk("bp_in_ready_c1", 32'(in_ready), 32'd0);
    chk("bp_op1_refresh", out_op1, 32'hDEAD);
    chk("bp_op2_stable_c1", out_op2, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_in_ready_c2", 32'(in_ready), 32'd0);
    chk("bp_op1_held", out_op1, 32'hDEAD);
    chk("bp_op2_stable_c2", out_op2, 32'd1);
    chk("bp_rd_stable", 32'(out_rd), 32'd6);
    @(posedge clk); #1;
    out_ready = 1'b1;
    expect_b(7'h33, 3'd0, 7'h00, 5'd2, 32'hDEAD, 32'hDEAD, 1'b0);
    @(negedge clk);
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    idle(2);

    // Same-cycle bypass, writeback to x0 ignored, x7 then read from storage
    expect_b(7'h33, 3'd0, 7'h00, 5'd4, 32'hA5, 32'd0, 1'b0);
    wb_en = 1'b1; wb_rd = 5'd7; wb_data = 32'hA5;
    send(32'h00038233);
    wb_rd = 5'd0; wb_data = 32'hFFFF;
    expect_b(7'h33, 3'd0, 7'h00, 5'd8, 32'd0, 32'd0, 1'b0);
    send(32'h00000433);
    wb_en = 1'b0;
    expect_b(7'h33, 3'd0, 7'h00, 5'd9, 32'd0, 32'hA5, 1'b0);
    send(32'h007004B3);
    idle(2);

    // Flush together with an accept drops the instruction
    in_valid = 1'b1; in_instr = 32'h00500093; flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush_accept_dropped", 32'(out_valid), 32'd0);

    // Flush a stalled bundle
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(32'h00500093);
    @(negedge clk);
    chk("flush_held_before", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_held_after", 32'(out_valid), 32'd0);

    // Asynchronous reset while a bundle is held
    @(posedge clk); #1;
    send(32'h00108313);
    @(negedge clk);
    chk("arst_held_before", 32'(out_valid), 32'd1);
    chk("arst_op1_before", out_op1, 32'hDEAD);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_op1", out_op1, 32'd0);
    chk("arst_rd", 32'(out_rd), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    expect_b(7'h33, 3'd0, 7'h00, 5'd2, 32'd0, 32'd0, 1'b0);
    send(32'h00108133);
    expect_b(7'h33, 3'd0, 7'h00, 5'd9, 32'd0, 32'd0, 1'b0);
    send(32'h007004B3);

    for (int i = 0; i < 20; i++) begin
      if (q.size() == 0) break;
      @(negedge clk);
    end
    @(posedge clk); #1;
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
